// File: rtl/register_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : register_write_buffer
// Purpose  : Three-slot write-back buffer; ages writes 2 -> 1 -> 0 and commits
//            slot 0 to the integer/float register file, exposing all slots.
// Revision : 1.0 - initial release
// ============================================================================
module register_write_buffer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  write_enable,
    input  logic [4:0]            write_addr,
    input  logic                  write_float,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  write_enable_0,
    output logic                  write_enable_1,
    output logic                  write_enable_2,
    output logic [4:0]            write_addr_0,
    output logic [4:0]            write_addr_1,
    output logic [4:0]            write_addr_2,
    output logic                  write_float_0,
    output logic                  write_float_1,
    output logic                  write_float_2,
    output logic [DATA_WIDTH-1:0] write_data_0,
    output logic [DATA_WIDTH-1:0] write_data_1,
    output logic [DATA_WIDTH-1:0] write_data_2,
    output logic                  commit_enable,
    output logic [4:0]            commit_addr,
    output logic                  commit_float,
    output logic [DATA_WIDTH-1:0] commit_data,
    output logic [1:0]            pending,
    output logic                  empty
);

    localparam logic [4:0] c_ZERO_ADDR = 5'd0;

    logic                  r_en_0, r_en_1, r_en_2;
    logic [4:0]            r_addr_0, r_addr_1, r_addr_2;
    logic                  r_float_0, r_float_1, r_float_2;
    logic [DATA_WIDTH-1:0] r_data_0, r_data_1, r_data_2;

    logic                  w_accept;

    // Integer $zero is hard-wired; float f0 is an ordinary register.
    assign w_accept = write_enable & ~((write_addr == c_ZERO_ADDR) & ~write_float);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_en_0    <= 1'b0;
            r_en_1    <= 1'b0;
            r_en_2    <= 1'b0;
            r_addr_0  <= '0;
            r_addr_1  <= '0;
            r_addr_2  <= '0;
            r_float_0 <= 1'b0;
            r_float_1 <= 1'b0;
            r_float_2 <= 1'b0;
            r_data_0  <= '0;
            r_data_1  <= '0;
            r_data_2  <= '0;
        end else if (!stall) begin
            r_en_0    <= r_en_1;
            r_addr_0  <= r_addr_1;
            r_float_0 <= r_float_1;
            r_data_0  <= r_data_1;
            r_en_1    <= r_en_2;
            r_addr_1  <= r_addr_2;
            r_float_1 <= r_float_2;
            r_data_1  <= r_data_2;
            // Payload fields load unconditionally; only the enable is filtered.
            r_en_2    <= w_accept;
            r_addr_2  <= write_addr;
            r_float_2 <= write_float;
            r_data_2  <= write_data;
        end
    end

    assign write_enable_0 = r_en_0;
    assign write_enable_1 = r_en_1;
    assign write_enable_2 = r_en_2;
    assign write_addr_0   = r_addr_0;
    assign write_addr_1   = r_addr_1;
    assign write_addr_2   = r_addr_2;
    assign write_float_0  = r_float_0;
    assign write_float_1  = r_float_1;
    assign write_float_2  = r_float_2;
    assign write_data_0   = r_data_0;
    assign write_data_1   = r_data_1;
    assign write_data_2   = r_data_2;

    // Slot 0 stays visible through its commit edge, closing the forwarding gap.
    assign commit_enable  = r_en_0 & ~stall;
    assign commit_addr    = r_addr_0;
    assign commit_float   = r_float_0;
    assign commit_data    = r_data_0;

    assign pending = {1'b0, r_en_0} + {1'b0, r_en_1} + {1'b0, r_en_2};
    assign empty   = ~(r_en_0 | r_en_1 | r_en_2);

endmodule
`default_nettype wire

// File: tb/tb_register_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_write_buffer
// Purpose  : Directed scoreboard bench for register_write_buffer commits and slots.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_write_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic        write_float;
    logic [31:0] write_data;
    logic        write_enable_0, write_enable_1, write_enable_2;
    logic [4:0]  write_addr_0, write_addr_1, write_addr_2;
    logic        write_float_0, write_float_1, write_float_2;
    logic [31:0] write_data_0, write_data_1, write_data_2;
    logic        commit_enable;
    logic [4:0]  commit_addr;
    logic        commit_float;
    logic [31:0] commit_data;
    logic [1:0]  pending;
    logic        empty;

    int checks = 0;
    int errors = 0;
    logic [37:0] r_exp_q [$];

    register_write_buffer #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .write_enable(write_enable), .write_addr(write_addr),
        .write_float(write_float), .write_data(write_data),
        .write_enable_0(write_enable_0), .write_enable_1(write_enable_1),
        .write_enable_2(write_enable_2),
        .write_addr_0(write_addr_0), .write_addr_1(write_addr_1),
        .write_addr_2(write_addr_2),
        .write_float_0(write_float_0), .write_float_1(write_float_1),
        .write_float_2(write_float_2),
        .write_data_0(write_data_0), .write_data_1(write_data_1),
        .write_data_2(write_data_2),
        .commit_enable(commit_enable), .commit_addr(commit_addr),
        .commit_float(commit_float), .commit_data(commit_data),
        .pending(pending), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Presents one input set for one clock edge; accepted writes go to the scoreboard.
    task automatic cyc(input logic we, input logic [4:0] a, input logic f,
                       input logic [31:0] d, input logic st);
        write_enable = we;
        write_addr   = a;
        write_float  = f;
        write_data   = d;
        stall        = st;
        if (we && !(a == 5'd0 && !f) && !st && !reset)
            r_exp_q.push_back({a, f, d});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    endtask

    // Monitor: every commit strobe must match the oldest outstanding accepted write.
    always @(negedge clk) begin
        if (commit_enable === 1'b1) begin
            if (r_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL commit_unexpected actual=%0h/%0h/%0h required=none",
                         commit_addr, commit_float, commit_data);
            end else begin
                chk("commit", {26'd0, commit_addr, commit_float, commit_data},
                    {26'd0, r_exp_q.pop_front()});
            end
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0; write_enable = 1'b0;
        write_addr = '0; write_float = 1'b0; write_data = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_empty", {63'd0, empty}, 64'd1);
        chk("rst_pending", {62'd0, pending}, 64'd0);

        // Fill with r3, r4, r5, then reset while stalled so nothing commits.
        cyc(1'b1, 5'd3, 1'b0, 32'h33, 1'b0);
        cyc(1'b1, 5'd4, 1'b0, 32'h44, 1'b0);
        cyc(1'b1, 5'd5, 1'b0, 32'h55, 1'b0);
        chk("full_pending", {62'd0, pending}, 64'd3);
        reset = 1'b1; stall = 1'b1; write_enable = 1'b0;
        @(negedge clk);
        chk("rst_cycle_commit", {63'd0, commit_enable}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        r_exp_q.delete();
        chk("rst_enables", {61'd0, write_enable_2, write_enable_1, write_enable_0}, 64'd0);
        chk("rst_pending2", {62'd0, pending}, 64'd0);
        chk("rst_empty2", {63'd0, empty}, 64'd1);
        chk("rst_addr0", {59'd0, write_addr_0}, 64'd0);

        // Single write r7 = 0x1234 ages through the slots.
        cyc(1'b1, 5'd7, 1'b0, 32'h1234, 1'b0);
        chk("r7_slot2", {26'd0, write_enable_2, write_addr_2, write_data_2}, {26'd0, 1'b1, 5'd7, 32'h1234});
        idle();
        chk("r7_slot1", {26'd0, write_enable_1, write_addr_1, write_data_1}, {26'd0, 1'b1, 5'd7, 32'h1234});
        idle();
        chk("r7_slot0", {26'd0, write_enable_0, write_addr_0, write_data_0}, {26'd0, 1'b1, 5'd7, 32'h1234});
        chk("r7_commit_en", {63'd0, commit_enable}, 64'd1);
        idle();
        chk("r7_empty", {63'd0, empty}, 64'd1);

        // Back-to-back r1=1, r1=2, f1=3.
        cyc(1'b1, 5'd1, 1'b0, 32'd1, 1'b0);
        cyc(1'b1, 5'd1, 1'b0, 32'd2, 1'b0);
        cyc(1'b1, 5'd1, 1'b1, 32'd3, 1'b0);
        chk("b2b_slot0", {26'd0, write_addr_0, write_float_0, write_data_0}, {26'd0, 5'd1, 1'b0, 32'd1});
        chk("b2b_slot1", {26'd0, write_addr_1, write_float_1, write_data_1}, {26'd0, 5'd1, 1'b0, 32'd2});
        chk("b2b_slot2", {26'd0, write_addr_2, write_float_2, write_data_2}, {26'd0, 5'd1, 1'b1, 32'd3});
        chk("b2b_pending", {62'd0, pending}, 64'd3);
        chk("b2b_not_empty", {63'd0, empty}, 64'd0);
        idle(); idle(); idle();
        chk("b2b_drained", {63'd0, empty}, 64'd1);

        // Integer r0 is dropped; float f0 is accepted.
        cyc(1'b1, 5'd0, 1'b0, 32'hFFFF, 1'b0);
        chk("r0_dropped", {63'd0, write_enable_2}, 64'd0);
        chk("r0_pending", {62'd0, pending}, 64'd0);
        cyc(1'b1, 5'd0, 1'b1, 32'hFFFF, 1'b0);
        chk("f0_slot2", {26'd0, write_enable_2, write_float_2, write_data_2}, {26'd0, 1'b1, 1'b1, 32'hFFFF});
        idle(); idle(); idle();
        chk("f0_drained", {63'd0, empty}, 64'd1);

        // r9 reaches slot 0, then two stalled cycles while r10 is offered.
        cyc(1'b1, 5'd9, 1'b0, 32'h99, 1'b0);
        idle(); idle();
        cyc(1'b1, 5'd10, 1'b0, 32'hAA, 1'b1);
        chk("stall1_commit", {63'd0, commit_enable}, 64'd0);
        chk("stall1_slot0", {57'd0, write_enable_0, write_addr_0, write_float_0}, {57'd0, 1'b1, 5'd9, 1'b0});
        chk("stall1_slot2", {63'd0, write_enable_2}, 64'd0);
        cyc(1'b1, 5'd10, 1'b0, 32'hAA, 1'b1);
        chk("stall2_commit", {63'd0, commit_enable}, 64'd0);
        chk("stall2_pending", {62'd0, pending}, 64'd1);
        chk("stall2_slot0", {26'd0, write_addr_0, write_data_0}, {27'd0, 5'd9, 32'h99});
        idle();
        chk("stall_release_empty", {63'd0, empty}, 64'd1);

        // Ten writes with interleaved stalls; the scoreboard checks commit order.
        for (int i = 0; i < 10; i++) begin
            while ($urandom_range(0, 2) == 0)
                cyc(1'b1, 5'(i + 11), 1'(i % 2), 32'(32'hC0DE0000 + i), 1'b1);
            cyc(1'b1, 5'(i + 11), 1'(i % 2), 32'(32'hC0DE0000 + i), 1'b0);
        end
        for (int k = 0; k < 4; k++) idle();
        chk("stream_drained", {63'd0, empty}, 64'd1);
        chk("scoreboard_empty", 64'(r_exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
